alu_share_arb: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_share_arb_rr_pick.sv | 28 ++
 rtl/alu_share_arb.sv | 130 +++++++++++++
 tb/tb_alu_share_arb.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and widths for the shared-ALU arbiter and its helpers.
package alu_pkg;
  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_NAND = 2'b10,
    OP_XOR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } arb_state_e;
endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, searching upward with wrap.
module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt_oh,
  output logic [IDW-1:0] idx,
  output logic           any_req
);
  int slot;

  always_comb begin
    gnt_oh  = '0;
    idx     = '0;
    any_req = 1'b0;
    slot    = 0;
    for (int k = 0; k < N; k++) begin
      slot = (int'(ptr) + k) % N;
      if (!any_req && req[slot]) begin
        any_req      = 1'b1;
        gnt_oh[slot] = 1'b1;
        idx          = IDW'(slot);
      end
    end
  end
endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one external 4-bit ALU between NUM_REQ requesters,
// with a valid/ready response channel and a saturating overflow counter.
//
// state   | meaning
// ST_IDLE | waiting for a request; grant pulse and operand capture happen here
// ST_EXEC | operands on the ALU bus, result captured at the end of this cycle
// ST_RESP | response held until the consumer accepts it
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ID_W     = 1,
  parameter int ERRCNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [2*NUM_REQ-1:0]    req_op,
  input  logic [4*NUM_REQ-1:0]    req_in1,
  input  logic [4*NUM_REQ-1:0]    req_in2,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [1:0]              alu_op,
  output logic [ALU_W-1:0]        alu_in1,
  output logic [ALU_W-1:0]        alu_in2,
  input  logic [ALU_W-1:0]        alu_out,
  input  logic                    alu_err,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [ALU_W-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic [ERRCNT_W-1:0]     err_cnt
);
  arb_state_e            state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d, id_q, id_d;
  logic [1:0]            op_q, op_d;
  logic [ALU_W-1:0]      in1_q, in1_d, in2_q, in2_d, data_q, data_d;
  logic                  valid_q, valid_d, err_q, err_d;
  logic [ERRCNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [ID_W-1:0]       pick_idx;
  logic                  pick_any;

  rr_pick #(.N(NUM_REQ), .IDW(ID_W)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_oh  (pick_gnt),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt     = pick_gnt;
          op_d    = req_op[2*pick_idx +: 2];
          in1_d   = req_in1[ALU_W*pick_idx +: ALU_W];
          in2_d   = req_in2[ALU_W*pick_idx +: ALU_W];
          id_d    = pick_idx;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        data_d  = alu_out;
        err_d   = alu_err;
        valid_d = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // valid is always set in RESP, so ready alone completes the handshake
        if (rsp_ready) begin
          valid_d = 1'b0;
          ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          if (err_q && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) gnt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_op    = op_q;
  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign rsp_valid = valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign err_cnt   = cnt_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int N   = 3;
  localparam int IDW = 2;
  localparam int EW  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [2*N-1:0]   req_op;
  logic [4*N-1:0]   req_in1, req_in2;
  logic [N-1:0]     gnt;
  logic [1:0]       alu_op;
  logic [3:0]       alu_in1, alu_in2, alu_out;
  logic             alu_err;
  logic             rsp_valid, rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [3:0]       rsp_data;
  logic             rsp_err;
  logic [EW-1:0]    err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;
  int m_errs  = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.NUM_REQ(N), .ID_W(IDW), .ERRCNT_W(EW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_in1(req_in1), .req_in2(req_in2),
    .gnt(gnt), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_err(alu_err), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .err_cnt(err_cnt)
  );

  // 4-bit two's complement ALU computed with plain integer arithmetic: {err, data}
  function automatic logic [4:0] ref_alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int sa, sb, s;
    logic [3:0] d;
    logic e;
    sa = (a > 7) ? int'(a) - 16 : int'(a);
    sb = (b > 7) ? int'(b) - 16 : int'(b);
    s = 0;
    e = 1'b0;
    case (op)
      2'b00: begin s = sa + sb; d = 4'(a + b); e = (s > 7) || (s < -8); end
      2'b01: begin s = sa - sb; d = 4'(a - b); e = (s > 7) || (s < -8); end
      2'b10: d = ~(a & b);
      default: d = a ^ b;
    endcase
    return {e, d};
  endfunction

  assign {alu_err, alu_out} = ref_alu(alu_op, alu_in1, alu_in2);

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic on, input logic [1:0] op,
                         input logic [3:0] a, input logic [3:0] b);
    req[i] = on;
    req_op[2*i +: 2] = op;
    req_in1[4*i +: 4] = a;
    req_in2[4*i +: 4] = b;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; req_op = '0; req_in1 = '0; req_in2 = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); req = '1; #1;
    n_tests++;
    if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    n_tests++;
    if ({alu_op, alu_in1, alu_in2, rsp_valid, rsp_id, rsp_data, rsp_err, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: op=%h in1=%h in2=%h v=%b id=%0d d=%h e=%b cnt=%0d want all 0",
               alu_op, alu_in1, alu_in2, rsp_valid, rsp_id, rsp_data, rsp_err, err_cnt);
    end
    req = '0;
    @(negedge clk); rst = 1'b0;
    m_ptr = 0; m_errs = 0;
  endtask

  task automatic test_ops;
    int         t_id [5] = '{0, 1, 1, 0, 1};
    logic [1:0] t_op [5] = '{OP_ADD, OP_ADD, OP_SUB, OP_NAND, OP_XOR};
    logic [3:0] t_a  [5] = '{4'd3, 4'd7, 4'd8, 4'hC, 4'hC};
    logic [3:0] t_b  [5] = '{4'd2, 4'd1, 4'd1, 4'hA, 4'hA};
    logic [3:0] t_d  [5] = '{4'd5, 4'h8, 4'h7, 4'h7, 4'h6};
    logic       t_e  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); set_req(t_id[k], 1'b1, t_op[k], t_a[k], t_b[k]); #1;
      n_tests++;
      if (gnt !== (N'(1) << t_id[k])) begin
        n_fail++; $display("FAIL ops_gnt[%0d]: got %b want %b", k, gnt, N'(1) << t_id[k]);
      end
      @(negedge clk); set_req(t_id[k], 1'b0, 2'b00, 4'h0, 4'h0); #1;
      n_tests++;
      if ({gnt, rsp_valid, alu_op, alu_in1, alu_in2} !== {N'(0), 1'b0, t_op[k], t_a[k], t_b[k]}) begin
        n_fail++;
        $display("FAIL ops_exec[%0d]: gnt=%b v=%b op=%h in1=%h in2=%h want gnt=0 v=0 op=%h in1=%h in2=%h",
                 k, gnt, rsp_valid, alu_op, alu_in1, alu_in2, t_op[k], t_a[k], t_b[k]);
      end
      @(negedge clk); #1;
      n_tests++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, IDW'(t_id[k]), t_d[k], t_e[k]}) begin
        n_fail++;
        $display("FAIL ops_rsp[%0d]: v=%b id=%0d d=%h e=%b want v=1 id=%0d d=%h e=%b",
                 k, rsp_valid, rsp_id, rsp_data, rsp_err, t_id[k], t_d[k], t_e[k]);
      end
      m_errs += int'(t_e[k]);
      m_ptr = (t_id[k] + 1) % N;
      @(negedge clk); #1;
      n_tests++;
      if ({rsp_valid, err_cnt} !== {1'b0, EW'(m_errs)}) begin
        n_fail++; $display("FAIL ops_post[%0d]: v=%b cnt=%0d want v=0 cnt=%0d", k, rsp_valid, err_cnt, m_errs);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [IDW+5:0] snap;
    @(negedge clk); set_req(0, 1'b1, OP_XOR, 4'h5, 4'h3); rsp_ready = 1'b0; #1;
    n_tests++;
    if (gnt !== 3'b001) begin n_fail++; $display("FAIL bp_gnt0: got %b want 001", gnt); end
    @(negedge clk); set_req(0, 1'b0, 2'b00, 4'h0, 4'h0); set_req(1, 1'b1, OP_SUB, 4'h2, 4'h5); #1;
    n_tests++;
    if (gnt !== '0) begin n_fail++; $display("FAIL bp_exec_gnt: got %b want 0", gnt); end
    @(negedge clk); #1;
    snap = {rsp_valid, rsp_id, rsp_data, rsp_err};
    n_tests++;
    if (snap !== {1'b1, IDW'(0), 4'h6, 1'b0}) begin
      n_fail++; $display("FAIL bp_rsp: got %h want %h", snap, {1'b1, IDW'(0), 4'h6, 1'b0});
    end
    for (int t = 0; t < 5; t++) begin
      @(negedge clk); #1;
      n_tests++;
      if ({gnt, rsp_valid, rsp_id, rsp_data, rsp_err} !== {N'(0), snap}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: gnt=%b rsp=%h want gnt=0 rsp=%h", t, gnt,
                           {rsp_valid, rsp_id, rsp_data, rsp_err}, snap);
      end
    end
    @(negedge clk); rsp_ready = 1'b1;
    m_ptr = 1;
    @(negedge clk); #1;
    n_tests++;
    if ({rsp_valid, gnt} !== {1'b0, 3'b010}) begin
      n_fail++; $display("FAIL bp_release: v=%b gnt=%b want v=0 gnt=010", rsp_valid, gnt);
    end
    @(negedge clk); set_req(1, 1'b0, 2'b00, 4'h0, 4'h0);
    @(negedge clk); #1;
    n_tests++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, IDW'(1), 4'hD, 1'b0}) begin
      n_fail++; $display("FAIL bp_rsp2: v=%b id=%0d d=%h e=%b want v=1 id=1 d=d e=0",
                         rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    m_ptr = 2;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int c = 0, prev_c = 0, got, exp_w;
    @(posedge clk); #1;
    set_req(0, 1'b1, OP_ADD, 4'h1, 4'h1);
    set_req(1, 1'b1, OP_NAND, 4'hC, 4'hA);
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      got = -1;
      for (int t = 0; t < 8 && got < 0; t++) begin
        @(negedge clk); #1; c++;
        if (gnt !== '0) got = k;
      end
      exp_w = pick(req, m_ptr);
      n_tests++;
      if (got < 0) begin
        n_fail++; $display("FAIL b2b_timeout[%0d]: no gnt within 8 cycles, want gnt to %0d", k, exp_w);
      end else begin
        if (gnt !== (N'(1) << exp_w) || (k > 0 && c - prev_c != 3)) begin
          n_fail++; $display("FAIL b2b_gnt[%0d]: gnt=%b gap=%0d want gnt=%b gap=3", k, gnt, c - prev_c,
                             N'(1) << exp_w);
        end
        prev_c = c;
        m_ptr = (exp_w + 1) % N;
      end
    end
    @(negedge clk); set_req(0, 1'b0, 2'b00, 4'h0, 4'h0); set_req(1, 1'b0, 2'b00, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk); set_req(0, 1'b1, OP_ADD, 4'h7, 4'h1); #1;
    n_tests++;
    if (gnt !== 3'b001) begin n_fail++; $display("FAIL rmid_gnt: got %b want 001", gnt); end
    @(negedge clk); rst = 1'b1; set_req(1, 1'b1, OP_XOR, 4'h1, 4'h2); set_req(2, 1'b1, OP_XOR, 4'h3, 4'h4); #1;
    n_tests++;
    if (gnt !== '0) begin n_fail++; $display("FAIL rmid_rst_gnt: got %b want 0", gnt); end
    @(negedge clk); #1;
    n_tests++;
    if ({gnt, alu_op, alu_in1, alu_in2, rsp_valid, rsp_id, rsp_data, rsp_err, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL rmid_outputs: gnt=%b op=%h in1=%h in2=%h v=%b id=%0d d=%h e=%b cnt=%0d want all 0",
               gnt, alu_op, alu_in1, alu_in2, rsp_valid, rsp_id, rsp_data, rsp_err, err_cnt);
    end
    rst = 1'b0; #1;
    n_tests++;
    if (gnt !== 3'b001) begin n_fail++; $display("FAIL rmid_first_gnt: got %b want 001", gnt); end
    @(negedge clk); req = '0;
    @(negedge clk); #1;
    n_tests++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, IDW'(0), 4'h8, 1'b1}) begin
      n_fail++; $display("FAIL rmid_rsp: v=%b id=%0d d=%h e=%b want v=1 id=0 d=8 e=1",
                         rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    m_ptr = 1; m_errs = 1;
    @(negedge clk); #1;
    n_tests++;
    if (err_cnt !== EW'(m_errs)) begin n_fail++; $display("FAIL rmid_cnt: got %0d want %0d", err_cnt, m_errs); end
  endtask

  task automatic test_saturate;
    int  total = m_errs;
    bit  chk255 = 1'b0;
    @(posedge clk); #1;
    set_req(0, 1'b1, OP_ADD, 4'h7, 4'h1);
    rsp_ready = 1'b1;
    for (int t = 0; t < 2000 && total < 256; t++) begin
      @(negedge clk); #1;
      if (total == 255 && !chk255) begin
        chk255 = 1'b1;
        n_tests++;
        if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_255: got %h want ff", err_cnt); end
      end
      if (rsp_valid) total++;
    end
    @(negedge clk); req = '0; #1;
    n_tests++;
    if (total < 256 || err_cnt !== 8'hFF) begin
      n_fail++; $display("FAIL sat_256: responses=%0d cnt=%h want responses=256 cnt=ff", total, err_cnt);
    end
    m_errs = 255;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random;
    logic       r_req [N];
    logic [1:0] r_op  [N];
    logic [3:0] r_a   [N], r_b [N];
    bit         busy = 1'b0;
    int         age = 0, t_id = 0, exp_w;
    logic [1:0] t_op = '0;
    logic [3:0] t_a = '0, t_b = '0, t_data = '0;
    logic       t_err = 1'b0, exp_v;
    logic [N-1:0] exp_g;
    rst = 1'b1; req = '0;
    for (int i = 0; i < N; i++) begin r_req[i] = 1'b0; r_op[i] = '0; r_a[i] = '0; r_b[i] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    m_ptr = 0; m_errs = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!r_req[i] && cyc < 560 && $urandom_range(0, 2) == 0) begin
          r_req[i] = 1'b1;
          r_op[i] = 2'($urandom_range(0, 3));
          r_a[i] = 4'($urandom_range(0, 15));
          r_b[i] = 4'($urandom_range(0, 15));
        end
        set_req(i, r_req[i], r_op[i], r_a[i], r_b[i]);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_w = busy ? -1 : pick(req, m_ptr);
      exp_g = (exp_w >= 0) ? (N'(1) << exp_w) : '0;
      exp_v = busy && (age >= 2);
      n_tests++;
      if (gnt !== exp_g) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b want %b", cyc, gnt, exp_g); end
      n_tests++;
      if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, rsp_valid, exp_v); end
      if (busy && age == 1) begin
        n_tests++;
        if ({alu_op, alu_in1, alu_in2} !== {t_op, t_a, t_b}) begin
          n_fail++; $display("FAIL rnd_alu_bus@%0d: got %h %h %h want %h %h %h", cyc, alu_op, alu_in1, alu_in2,
                             t_op, t_a, t_b);
        end
      end
      if (exp_v) begin
        n_tests++;
        if ({rsp_id, rsp_err, rsp_data} !== {IDW'(t_id), t_err, t_data}) begin
          n_fail++; $display("FAIL rnd_rsp@%0d: id=%0d e=%b d=%h want id=%0d e=%b d=%h", cyc, rsp_id, rsp_err,
                             rsp_data, t_id, t_err, t_data);
        end
      end
      n_tests++;
      if (err_cnt !== EW'(m_errs)) begin n_fail++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", cyc, err_cnt, m_errs); end
      if (exp_v && rsp_ready) begin
        if (t_err && m_errs < 255) m_errs++;
        m_ptr = (t_id + 1) % N;
        busy = 1'b0;
      end
      if (exp_w >= 0) begin
        busy = 1'b1; age = 0; t_id = exp_w;
        t_op = r_op[exp_w]; t_a = r_a[exp_w]; t_b = r_b[exp_w];
        {t_err, t_data} = ref_alu(t_op, t_a, t_b);
        if ($urandom_range(0, 1) == 0) r_req[exp_w] = 1'b0;
        else begin
          r_op[exp_w] = 2'($urandom_range(0, 3));
          r_a[exp_w] = 4'($urandom_range(0, 15));
          r_b[exp_w] = 4'($urandom_range(0, 15));
        end
      end
      if (busy) age++;
    end
  endtask

  initial begin
    test_reset;
    test_ops;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_saturate;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog expired");
  end
endmodule
